// File: rtl/fadd_pack_if.sv
// Handshake bundle between the mantissa adder, the packing stage and the FPU result mux.
// master drives operands and consumes results; slave is the packing stage itself.
interface fadd_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [36:0] in_data;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_flags;

  modport master (
    output in_valid, in_data, in_rm, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, in_rm, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fadd_pack.sv
// Purpose: pack the 37-bit extended adder result into an IEEE single with flags.
// Latency: result valid 3+k cycles after accept (k = normalization shifts, 0..25).
// Backpressure: one operation in flight; result held in DONE until out_ready.
module fadd_pack (
  input  logic        clk,
  input  logic        rst,
  fadd_pack_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, DONE} state_t;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [27:0] mant;
  } ext_t;

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  state_t      state, state_nxt;
  logic        s, s_nxt;
  logic [9:0]  e, e_nxt;
  logic [27:0] m, m_nxt;
  logic [2:0]  rm, rm_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] od, od_nxt;
  logic [4:0]  of, of_nxt;

  ext_t        in_ext;
  logic [27:0] m_a, m_sh;
  logic [9:0]  e_a, e_sh;

  logic        lsb, g, r, st, nx, inc, to_inf;
  logic [24:0] sum;
  logic [27:0] m_r, m_r2;
  logic [9:0]  e_r;
  logic [7:0]  exp_f;
  logic [31:0] rnd_data;
  logic [4:0]  rnd_flags;

  assign in_ext = ext_t'(bus.in_data);

  // Carry correction keeps the shifted-out bit folded into sticky.
  always_comb begin
    m_a = m;
    e_a = e;
    if (m[27]) begin
      m_a = {1'b0, m[27:2], m[1] | m[0]};
      e_a = e + 10'd1;
    end
  end

  assign m_sh = {m[26:0], 1'b0};
  assign e_sh = e - 10'd1;

  always_comb begin
    lsb = m[3];
    g   = m[2];
    r   = m[1];
    st  = m[0];
    nx  = g | r | st;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = nx & s;
      RM_RUP:  inc = nx & ~s;
      RM_RMM:  inc = g;
      default: inc = g & (r | st | lsb);
    endcase
    sum = m[27:3] + {24'd0, inc};
    m_r = {sum, m[2:0]};
    m_r2 = m_r;
    e_r  = e;
    if (m_r[27]) begin
      m_r2 = {1'b0, m_r[27:1]};
      e_r  = e + 10'd1;
    end
    exp_f  = m_r2[26] ? e_r[7:0] : 8'h00;
    // Directed modes that round away from infinity saturate to max finite.
    to_inf = !((rm == RM_RTZ) || (rm == RM_RDN && !s) || (rm == RM_RUP && s));

    rnd_data  = {s, exp_f, m_r2[25:3]};
    rnd_flags = {3'b000, nx && (exp_f == 8'h00), nx};
    if (m_r2 == 28'd0) begin
      rnd_data  = {s, 31'd0};
      rnd_flags = 5'b00000;
    end else if (e_r >= 10'd255) begin
      rnd_flags = 5'b00101;
      rnd_data  = to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    e_nxt     = e;
    m_nxt     = m;
    rm_nxt    = rm;
    cnt_nxt   = cnt;
    od_nxt    = od;
    of_nxt    = of;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          s_nxt     = in_ext.sign;
          e_nxt     = {2'b00, (in_ext.exp == 8'h00) ? 8'h01 : in_ext.exp};
          m_nxt     = in_ext.mant;
          rm_nxt    = bus.in_rm;
          cnt_nxt   = 5'd0;
          state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        m_nxt = m_a;
        e_nxt = e_a;
        if (!m_a[26] && (m_a != 28'd0) && (e_a > 10'd1)) state_nxt = NORM;
        else                                                state_nxt = ROUND;
      end
      NORM: begin
        m_nxt   = m_sh;
        e_nxt   = e_sh;
        cnt_nxt = cnt + 5'd1;
        // cnt < 24 caps the walk at 25 shifts even for a sticky-only mantissa.
        if (!m_sh[26] && (e_sh > 10'd1) && (cnt < 5'd24)) state_nxt = NORM;
        else                                               state_nxt = ROUND;
      end
      ROUND: begin
        od_nxt    = rnd_data;
        of_nxt    = rnd_flags;
        state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= 1'b0;
      e     <= 10'd0;
      m     <= 28'd0;
      rm    <= 3'd0;
      cnt   <= 5'd0;
      od    <= 32'd0;
      of    <= 5'd0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      e     <= e_nxt;
      m     <= m_nxt;
      rm    <= rm_nxt;
      cnt   <= cnt_nxt;
      od    <= od_nxt;
      of    <= of_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = od;
  assign bus.out_flags = of;

endmodule

// File: tb/tb_fadd_pack.sv
// Directed vector bench for fadd_pack: table of packed results plus handshake/reset sequences.
module tb_fadd_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fadd_pack_if bus ();
  fadd_pack dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [36:0] d;
    logic [2:0]  rm;
    logic [31:0] exp_d;
    logic [4:0]  exp_f;
    int          lat;
  } vec_t;

  vec_t vec [18];

  function automatic logic [36:0] mk(input logic sg, input logic [7:0] ex, input logic [27:0] mt);
    return {sg, ex, mt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand; returns the cycle (accept = 0) in which out_valid first rose.
  task automatic do_op(input logic [36:0] d, input logic [2:0] rm, input logic ordy,
                       output logic [31:0] od, output logic [4:0] of, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) chk("in_ready wait", 64'd0, 64'd1);
    bus.in_data   = d;
    bus.in_rm     = rm;
    bus.in_valid  = 1'b1;
    bus.out_ready = ordy;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 37'($urandom());
    bus.in_rm    = 3'($urandom());
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      tick();
      lat++;
    end
    od = bus.out_data;
    of = bus.out_flags;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [31:0] od;
    logic [4:0]  of;
    int          lat;
    int          seen;

    vec[0]  = '{mk(0, 8'h7F, 28'h4000000), 3'b000, 32'h3F800000, 5'b00000, 3};
    vec[1]  = '{mk(0, 8'h7F, 28'h8000000), 3'b000, 32'h40000000, 5'b00000, 3};
    vec[2]  = '{mk(0, 8'h7F, 28'h0800000), 3'b000, 32'h3E000000, 5'b00000, 6};
    vec[3]  = '{mk(0, 8'h7F, 28'h4000004), 3'b000, 32'h3F800000, 5'b00001, 3};
    vec[4]  = '{mk(0, 8'h7F, 28'h400000C), 3'b000, 32'h3F800002, 5'b00001, 3};
    vec[5]  = '{mk(0, 8'h7F, 28'h4000001), 3'b011, 32'h3F800001, 5'b00001, 3};
    vec[6]  = '{mk(0, 8'h7F, 28'h4000001), 3'b001, 32'h3F800000, 5'b00001, 3};
    vec[7]  = '{mk(0, 8'hFE, 28'h7FFFFFC), 3'b000, 32'h7F800000, 5'b00101, 3};
    vec[8]  = '{mk(0, 8'hFE, 28'h7FFFFFC), 3'b001, 32'h7F7FFFFF, 5'b00001, 3};
    vec[9]  = '{mk(1, 8'hFE, 28'h7FFFFFC), 3'b011, 32'hFF7FFFFF, 5'b00001, 3};
    vec[10] = '{mk(0, 8'h01, 28'h2000000), 3'b000, 32'h00400000, 5'b00000, 3};
    vec[11] = '{mk(0, 8'h01, 28'h2000004), 3'b000, 32'h00400000, 5'b00011, 3};
    vec[12] = '{mk(1, 8'h7F, 28'h0000000), 3'b000, 32'h80000000, 5'b00000, 3};
    vec[13] = '{mk(1, 8'h7F, 28'h4000001), 3'b010, 32'hBF800001, 5'b00001, 3};
    vec[14] = '{mk(0, 8'h7F, 28'h4000004), 3'b100, 32'h3F800001, 5'b00001, 3};
    vec[15] = '{mk(0, 8'h00, 28'h2000000), 3'b111, 32'h00400000, 5'b00000, 3};
    vec[16] = '{mk(0, 8'hFF, 28'h4000000), 3'b001, 32'h7F7FFFFF, 5'b00101, 3};
    vec[17] = '{mk(0, 8'h03, 28'h0800000), 3'b000, 32'h00400000, 5'b00000, 5};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_rm     = '0;
    bus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    chk("rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_data", 64'(bus.out_data), 64'd0);
    chk("rst out_flags", 64'(bus.out_flags), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 18; i++) begin
      do_op(vec[i].d, vec[i].rm, 1'b1, od, of, lat);
      chk($sformatf("v%0d data", i), 64'(od), 64'(vec[i].exp_d));
      chk($sformatf("v%0d flags", i), 64'(of), 64'(vec[i].exp_f));
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vec[i].lat));
      tick();
      chk($sformatf("v%0d release", i), 64'(bus.out_valid), 64'd0);
    end

    // Stalled consumer: result and handshake held for 5 cycles
    do_op(mk(0, 8'h7F, 28'h400000C), 3'b000, 1'b0, od, of, lat);
    chk("stall first data", 64'(od), 64'h3F800002);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall%0d out_valid", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall%0d out_data", c), 64'(bus.out_data), 64'h3F800002);
      chk($sformatf("stall%0d out_flags", c), 64'(bus.out_flags), 64'h01);
      chk($sformatf("stall%0d in_ready", c), 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("stall release out_valid", 64'(bus.out_valid), 64'd0);
    chk("stall release in_ready", 64'(bus.in_ready), 64'd1);

    // Reset during the second NORM cycle discards the result
    bus.in_data  = mk(0, 8'h7F, 28'h0800000);
    bus.in_rm    = 3'b000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid-norm rst in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("after rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("after rst in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("discarded result never shown", 64'(seen), 64'd0);

    do_op(mk(0, 8'h7F, 28'h8000000), 3'b000, 1'b1, od, of, lat);
    chk("post-abort data", 64'(od), 64'h40000000);
    chk("post-abort flags", 64'(of), 64'h0);
    chk("post-abort latency", 64'(lat), 64'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fadd_pack.md
# fadd_pack

Result-packing stage of the FPU adder-subtractor. It takes the 37-bit internal extended format that the pre-add alignment and normalization path produces and converts it back to an IEEE-754 single-precision word. The conversion runs in this order: carry correction, iterative left normalization, RISC-V rounding, then overflow and subnormal packing. It is a multi-cycle unit with valid/ready handshakes on both sides and sits between the mantissa adder and the FPU result mux.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  in_data/in_rm valid.
- in_ready  out  1  equals (state==IDLE) && !rst.
- in_data  in  37  fields:
  - [36] sign.
  - [35:28] biased exponent; 0 is interpreted as 1.
  - [27] carry bit.
  - [26] hidden bit.
  - [25:3] fraction.
  - [2] guard; [1] round; [0] sticky.
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  32  packed IEEE single.
- out_flags  out  5  {NV,DZ,OF,UF,NX}; NV and DZ are always 0.

## Operation
- Datapath registers:
  - s: sign.
  - e: 10-bit unsigned exponent.
  - m: 28-bit mantissa.
  - rm: latched rounding mode.
- IDLE
  - On in_valid && in_ready: latch the input, setting e = max(exp,1).
  - Go to ALIGN.
- ALIGN
  - If m[27]: m = {1'b0, m[27:2], m[1]|m[0]} and e = e+1 (the sticky OR is kept).
  - Next state: NORM if the post-ALIGN m has m[26]==0 && m!=0 && e>1; otherwise ROUND.
- NORM
  - Each cycle: m = m<<1, e = e-1.
  - Stay in NORM while the next value still has m[26]==0 && e>1; otherwise go to ROUND.
  - At most 25 shifts.
- ROUND
  - Bits used: lsb=m[3], g=m[2], r=m[1], st=m[0]; NX = g|r|st.
  - Increment rule per mode:
    - RNE: g&(r|st|lsb).
    - RTZ: 0.
    - RDN: NX&s.
    - RUP: NX&~s.
    - RMM: g.
  - m[27:3] += inc. If this carries into m[27], shift right 1 and set e = e+1.
  - Then pack:
    - Overflow (e>=255): OF=NX=1.
      - Result is infinity (exp 0xFF, frac 0) for RNE and RMM, for RDN when s=1, and for RUP when s=0.
      - Otherwise the result is max finite (exp 0xFE, frac all ones).
    - Normal: exp field = m[26] ? e[7:0] : 0; frac = m[25:3].
    - Zero: m==0 gives {s,31'b0} with flags 0.
    - UF = NX && exp field==0, i.e. tininess is detected after rounding.
  - Register out_data and out_flags; go to DONE.
- DONE
  - out_valid=1; out_data and out_flags are held stable.
  - On out_ready: go to IDLE.
  - in_ready stays 0 until IDLE, so there is no overlap of operations.

## Timing
- Reset values (one cycle of rst): state IDLE, out_valid=0, out_data=0, out_flags=0. in_ready=0 while rst is high and 1 in the cycle after.
- rst in any state, including mid-NORM or during DONE with a stalled consumer, aborts the operation. The pending result is discarded and never presented.
- Latency: take the accept cycle as cycle 0 and let k be the number of NORM shifts (0..25). out_valid is first asserted in cycle 3+k.
- Throughput is one result per 4+k cycles when out_ready is held at 1.
- in_data and in_rm are sampled only on the accepting edge; later changes are ignored.
- out_valid never deasserts without out_ready=1, except under rst.

## Test plan
- **Pass-through:** in_data={0,0x7F,0x4000000}, RNE → out_data 0x3F800000, flags 0, out_valid in cycle 3.
- **Carry, then normalization:**
  - exp 0x7F, m=0x8000000 → 0x40000000, cycle 3.
  - exp 0x7F, m=0x0800000 → 0x3E000000 (k=3), out_valid in cycle 6.
- **Rounding:**
  - m=0x4000004, exp 0x7F, RNE → 0x3F800000, NX.
  - m=0x400000C, RNE → 0x3F800002, NX.
  - m=0x4000001: RUP → 0x3F800001; RTZ → 0x3F800000; both NX.
- **Overflow:**
  - exp 0xFE, m=0x7FFFFFC, RNE → 0x7F800000, flags 5'b00101.
  - Same input, RTZ → 0x7F7FFFFF.
  - Same input with sign=1, RUP → 0xFF7FFFFF.
- **Subnormal and zero:**
  - exp 0x01, m=0x2000000 → 0x00400000, flags 0.
  - exp 0x01, m=0x2000004, RNE → 0x00400000, flags UF|NX.
  - m=0 with sign=1 → 0x80000000.
- **Handshake and reset:**
  - Hold out_ready=0 for 5 cycles in DONE → out_data and out_valid stable, in_ready=0.
  - Assert rst during the second NORM cycle → next cycle out_valid=0, in_ready=1. A new input then completes normally.
